mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for CPU bus accesses; the control unit/datapath is the initiator.
- Accepts one read or write request at a time over a four-phase req/ack handshake.
- Inserts a parameterised number of wait states, then performs the access on an internal word array.
- Returns read data and a completion/error status to the initiator.

Parameters:
- DW, 8, data word width in bits.
- AW, 8, address width in bits.
- DEPTH, 256, number of implemented words; valid addresses are 0..DEPTH-1, with DEPTH <= 2**AW.
- WAIT, 2, wait cycles inserted before the access, range 0..15.

Ports:
- clk  input  1  single system clock; all logic updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  1  request strobe from the initiator; held high until ack is seen.
- we  input  1  1 = write, 0 = read; sampled at acceptance.
- addr  input  AW  word address; sampled at acceptance.
- wdata  input  DW  write data; sampled at acceptance.
- rdata  output  DW  read data; valid while ack=1 for a read.
- ack  output  1  transaction complete; held until req is sampled low.
- err  output  1  address out of range; valid while ack=1.
- busy  output  1  transaction in progress (any state other than IDLE).

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, ack=0, err=0, busy=0, rdata=0, wait counter=0.
  - Array contents are not cleared.
  - rst has priority over every other event.
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - If req=1, latch we/addr/wdata, set busy=1 and load counter=WAIT.
  - Next state is WAIT if WAIT>0, else ACCESS.
  - If req=0, stay in IDLE.
- WAIT:
  - Counter decrements every cycle.
  - When the counter equals 1, go to ACCESS. Exactly WAIT cycles are spent in WAIT.
- ACCESS (single cycle; next state DONE, ack<=1):
  - Latched addr >= DEPTH: err<=1, no array write, rdata<=0.
  - Read: rdata<=mem[addr], err<=0.
  - Write: mem[addr]<=wdata, err<=0, rdata unchanged.
- DONE:
  - ack, err and rdata hold.
  - On the first edge where req=0: ack<=0, err<=0, busy<=0, next state IDLE.
- Latency: with req sampled high at edge k, ack is high after edge k+WAIT+1. ack falls on the edge after req is first sampled low.
- Minimum gap between transactions: a new req is accepted only in IDLE, at the earliest one edge after ack falls.
- Input changes after acceptance: changes on we/addr/wdata are ignored; the latched command is used.
- Early req drop: if req drops before ack, the transaction still completes. ack is high for exactly one cycle, because req=0 is already sampled in DONE.
- Reset mid-transaction:
  - A pending write in WAIT is discarded.
  - rst asserted on the ACCESS edge suppresses the write.
  - ack never rises for an aborted transaction.
- Read-after-write to the same address in back-to-back transactions returns the new data.

Test Plan:
1. Reset, WAIT=2: write addr=0x05, wdata=0xA5, handshake to completion, then read addr=0x05 -> ack rises 3 cycles after req is accepted; read rdata=0xA5, err=0.
2. WAIT=0: read addr=0x10 after writing 0x3C -> ack high after one edge, rdata=0x3C; hold req high 4 extra cycles -> ack and rdata hold for all 4; drop req -> ack=0 and busy=0 next edge.
3. DEPTH=200: write 0x77 to addr=0xC8 -> ack=1, err=1, no array change (a read of addr=0x00 still returns its prior value); a read of addr=0xFF -> err=1, rdata=0x00.
4. Change addr/wdata in the cycle after acceptance (0x05/0xA5 changed to 0x06/0x11) -> mem[0x05]=0xA5, mem[0x06] unchanged.
5. Assert rst for one cycle while in WAIT during a write of 0xFF to addr=0x02 -> ack never rises, busy=0; a later read of 0x02 returns the pre-reset value.
6. Pulse req for one cycle only (read addr=0x05, WAIT=3) -> ack high for exactly one cycle, 4 cycles after acceptance, rdata=0xA5; then IDLE.

Source files
------------

// File: rtl/mem_responder.sv
// Word-addressed memory responder answering one read/write at a time on a req/ack handshake.
// Latency: ack rises WAIT+1 edges after req is accepted; ack drops one edge after req is sampled low.
// Backpressure: a new req is accepted only in IDLE; inputs are latched at acceptance and then ignored.
module mem_responder #(
    parameter int DW    = 8,
    parameter int AW    = 8,
    parameter int DEPTH = 256,
    parameter int WAIT  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          ack,
    output logic          err,
    output logic          busy
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit HAS_WAIT = (WAIT > 0);
    localparam logic [3:0] WAIT_LD = 4'(WAIT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;

    logic [DW-1:0] mem [DEPTH];
    logic          in_range;
    logic [IW-1:0] mem_idx;
    logic          mem_wr;

    // Addresses at or beyond DEPTH are not backed by storage even when they fit in AW bits.
    assign in_range = ({1'b0, addr_q} < (AW+1)'(DEPTH));
    assign mem_idx  = addr_q[IW-1:0];
    assign mem_wr   = (state_q == S_ACCESS) && we_q && in_range;

    // Next-state and next-output computation for the handshake FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = ack_q;
        err_d   = err_q;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    busy_d  = 1'b1;
                    cnt_d   = WAIT_LD;
                    state_d = HAS_WAIT ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // <=1 rather than ==1 so a corrupted counter can never strand the FSM here.
                if (cnt_q <= 4'd1) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                ack_d   = 1'b1;
                state_d = S_DONE;
                if (!in_range) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    err_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = mem[mem_idx];
                    end
                end
            end
            S_DONE: begin
                if (!req) begin
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state, latched command and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Storage array; never cleared, and a reset on the access edge cancels the write.
    always_ff @(posedge clk) begin
        if (!rst && mem_wr) begin
            mem[mem_idx] <= wdata_q;
        end
    end

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT=2/DEPTH=200, WAIT=0, WAIT=3) share data inputs and rst.
// Each transaction is checked for latency, hold and release; results come from a table or a reference model.
// Each instance has its own req, so only one instance is ever mid-transaction.
module tb_mem_responder;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata [3];
    logic       ack   [3];
    logic       err   [3];
    logic       busy  [3];

    int vectors     = 0;
    int miscompares = 0;

    int wait_of  [3] = '{2, 0, 3};
    int depth_of [3] = '{200, 256, 256};

    // Reference model: a plain word store per instance plus the last returned rdata.
    bit [7:0] mmem   [3][256];
    bit       mknown [3][256];
    bit [7:0] mrd    [3];

    mem_responder #(.DW(8), .AW(8), .DEPTH(200), .WAIT(2)) u_d0 (
        .clk(clk), .rst(rst), .req(req[0]), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata[0]), .ack(ack[0]), .err(err[0]), .busy(busy[0]));
    mem_responder #(.DW(8), .AW(8), .DEPTH(256), .WAIT(0)) u_d1 (
        .clk(clk), .rst(rst), .req(req[1]), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata[1]), .ack(ack[1]), .err(err[1]), .busy(busy[1]));
    mem_responder #(.DW(8), .AW(8), .DEPTH(256), .WAIT(3)) u_d2 (
        .clk(clk), .rst(rst), .req(req[2]), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata[2]), .ack(ack[2]), .err(err[2]), .busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_txn(input int d, input bit w, input bit [7:0] a, input bit [7:0] wd,
                                      output bit e_err, output bit [7:0] e_rd, output bit e_known);
        e_known = 1'b1;
        if (int'(a) >= depth_of[d]) begin
            e_err = 1'b1;
            e_rd  = 8'h00;
        end else if (w) begin
            mmem[d][a]   = wd;
            mknown[d][a] = 1'b1;
            e_err        = 1'b0;
            e_rd         = mrd[d];
        end else begin
            e_err   = 1'b0;
            e_rd    = mmem[d][a];
            e_known = mknown[d][a];
        end
        mrd[d] = e_rd;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 3; d++) mrd[d] = 8'h00;
    endfunction

    // One full handshake; inputs are scrambled right after acceptance to prove they are latched.
    task automatic do_txn(input int d, input bit w, input bit [7:0] a, input bit [7:0] wd,
                          input int hold, input bit early,
                          output bit [7:0] o_rd, output bit o_err);
        int n;
        bit got;
        we     = w;
        addr   = a;
        wdata  = wd;
        req[d] = 1'b1;
        n      = 0;
        got    = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                addr  = a + 8'd1;
                wdata = 8'h11;
                we    = ~w;
                if (early) req[d] = 1'b0;
                check("busy_after_accept", busy[d], 1);
            end
            if (ack[d]) got = 1'b1;
        end
        if (!got) begin
            check("ack_timeout", 0, 1);
            o_rd  = 8'h00;
            o_err = 1'b0;
            req[d] = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            return;
        end
        check("ack_latency", n, wait_of[d] + 2);
        o_rd  = rdata[d];
        o_err = err[d];
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                check("ack_hold", ack[d], 1);
                check("rdata_hold", rdata[d], o_rd);
                check("err_hold", err[d], o_err);
            end
            req[d] = 1'b0;
        end
        @(posedge clk); #1;
        check("ack_release", ack[d], 0);
        check("busy_release", busy[d], 0);
        check("err_release", err[d], 0);
        check("rdata_after_release", rdata[d], o_rd);
    endtask

    typedef struct {
        int       d;
        bit       w;
        bit [7:0] a;
        bit [7:0] wd;
        int       hold;
        bit       chk_rd;
        bit [7:0] exp_rd;
        bit       exp_err;
    } vec_t;

    vec_t tbl [14];

    initial begin
        bit [7:0] rd, e_rd;
        bit       er, e_err, e_known;

        // Directed vectors: expectations written out by hand.
        tbl[0]  = '{0, 1'b1, 8'h06, 8'h66, 0, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{0, 1'b1, 8'h05, 8'hA5, 0, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{0, 1'b0, 8'h05, 8'h00, 0, 1'b1, 8'hA5, 1'b0};
        tbl[3]  = '{0, 1'b0, 8'h06, 8'h00, 1, 1'b1, 8'h66, 1'b0};
        tbl[4]  = '{0, 1'b1, 8'h00, 8'h3A, 0, 1'b1, 8'h66, 1'b0};
        tbl[5]  = '{0, 1'b1, 8'h02, 8'h5A, 0, 1'b0, 8'h00, 1'b0};
        tbl[6]  = '{0, 1'b1, 8'hC8, 8'h77, 2, 1'b1, 8'h00, 1'b1};
        tbl[7]  = '{0, 1'b0, 8'h00, 8'h00, 0, 1'b1, 8'h3A, 1'b0};
        tbl[8]  = '{0, 1'b0, 8'hFF, 8'h00, 0, 1'b1, 8'h00, 1'b1};
        tbl[9]  = '{1, 1'b1, 8'h10, 8'h3C, 0, 1'b1, 8'h00, 1'b0};
        tbl[10] = '{1, 1'b0, 8'h10, 8'h00, 4, 1'b1, 8'h3C, 1'b0};
        tbl[11] = '{1, 1'b1, 8'h20, 8'h12, 0, 1'b1, 8'h3C, 1'b0};
        tbl[12] = '{2, 1'b1, 8'h05, 8'hA5, 0, 1'b1, 8'h00, 1'b0};
        tbl[13] = '{1, 1'b0, 8'h20, 8'h00, 0, 1'b1, 8'h12, 1'b0};

        rst   = 1'b1;
        req   = 3'b000;
        we    = 1'b0;
        addr  = 8'h00;
        wdata = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check("reset_ack", ack[d], 0);
            check("reset_err", err[d], 0);
            check("reset_busy", busy[d], 0);
            check("reset_rdata", rdata[d], 0);
        end

        for (int i = 0; i < 14; i++) begin
            model_txn(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].wd, e_err, e_rd, e_known);
            do_txn(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].hold, 1'b0, rd, er);
            check("tbl_err", er, tbl[i].exp_err);
            if (tbl[i].chk_rd) check("tbl_rdata", rd, tbl[i].exp_rd);
        end

        // Early req drop on the WAIT=3 instance: ack for one cycle, 4 edges after acceptance.
        model_txn(2, 1'b0, 8'h05, 8'h00, e_err, e_rd, e_known);
        do_txn(2, 1'b0, 8'h05, 8'h00, 0, 1'b1, rd, er);
        check("early_drop_rdata", rd, 8'hA5);
        check("early_drop_err", er, 0);

        // Reset during WAIT of a write to 0x02: write discarded, ack never rises.
        we = 1'b1; addr = 8'h02; wdata = 8'hFF; req[0] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req[0] = 1'b0;
        model_reset();
        check("rst_wait_busy", busy[0], 0);
        check("rst_wait_rdata_other", rdata[1], 0);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("rst_wait_no_ack", ack[0], 0);
        end
        model_txn(0, 1'b0, 8'h02, 8'h00, e_err, e_rd, e_known);
        do_txn(0, 1'b0, 8'h02, 8'h00, 0, 1'b0, rd, er);
        check("rst_wait_mem_kept", rd, 8'h5A);

        // Reset on the ACCESS edge (WAIT=0 instance): write to 0x20 suppressed.
        we = 1'b1; addr = 8'h20; wdata = 8'hEE; req[1] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req[1] = 1'b0;
        model_reset();
        check("rst_access_busy", busy[1], 0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("rst_access_no_ack", ack[1], 0);
        end
        model_txn(1, 1'b0, 8'h20, 8'h00, e_err, e_rd, e_known);
        do_txn(1, 1'b0, 8'h20, 8'h00, 0, 1'b0, rd, er);
        check("rst_access_mem_kept", rd, 8'h12);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            int       d;
            bit       w;
            bit [7:0] a;
            bit [7:0] wd;
            int       hold;
            bit       early;
            d     = $urandom_range(0, 2);
            w     = 1'($urandom_range(0, 1));
            a     = (d == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 31));
            wd    = 8'($urandom);
            hold  = $urandom_range(0, 2);
            early = ($urandom_range(0, 4) == 0);
            model_txn(d, w, a, wd, e_err, e_rd, e_known);
            do_txn(d, w, a, wd, hold, early, rd, er);
            check("rand_err", er, e_err);
            if (e_known) check("rand_rdata", rd, e_rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
